div_share_arbiter: RTL and testbench
====================================

# div_share_arbiter

Round-robin arbiter and sequencer that shares one sequential 32-bit divider among several requesters in the gesture pipeline (area normalisation, perimeter/area ratio, Hu-moment scaling). It latches each requester's operands, issues one start pulse to the divider, waits for done, and returns the result to the granted requester with a one-cycle ack. It also handles zero-denominator bypass and a divider-timeout recovery.

## Interface
- N_REQ, 4, number of requesters (2..8)
- W, 32, operand/result width
- TIMEOUT, 64, max cycles spent in WAIT before aborting (≥ 2)

- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester request level; held high with operands stable until that requester's ack
- num_flat  in  N_REQ*W  numerators; requester i uses bits [i*W +: W]
- den_flat  in  N_REQ*W  denominators, same packing
- gnt  out  N_REQ  one-hot grant, high from ISSUE through DELIVER
- ack  out  N_REQ  one-hot, one-cycle result-valid pulse
- quotient  out  W  result, valid while ack high, held until next ack
- remainder  out  W  result, same validity as quotient
- div_zero  out  1  high with ack when the denominator was 0
- timeout_err  out  1  high with ack when the divider did not answer
- busy  out  1  high in any state other than IDLE
- div_start  out  1  single-cycle start pulse to the divider
- div_num, div_den  out  W each  operands to the divider, held stable from ISSUE until WAIT exits
- div_done  in  1  divider completion pulse
- div_quot, div_rem  in  W each  divider results, sampled on the cycle div_done is high

## Operation
- States: IDLE, ISSUE, WAIT, DELIVER.
- IDLE: if any req bit is high, select the winner by round-robin starting at index ptr, ascending modulo N_REQ. Latch the winner index and its num/den. Go to ISSUE.
- ISSUE: assert gnt[win].
  - den == 0: no div_start. Set quotient = all-ones, remainder = latched numerator, div_zero = 1. Go to DELIVER.
  - Otherwise: div_start = 1 for this cycle only, drive div_num/div_den, clear the timeout counter, go to WAIT.
- WAIT: the counter increments each cycle.
  - div_done = 1: capture div_quot/div_rem, go to DELIVER.
  - Otherwise, counter reaches TIMEOUT-1: set quotient = 0, remainder = 0, timeout_err = 1, go to DELIVER.
  - If div_done is high on the same cycle the counter reaches TIMEOUT-1, div_done wins and no error is flagged.
- DELIVER: ack[win] = 1 for exactly one cycle. Set ptr = (win+1) mod N_REQ. Go to IDLE. gnt drops when IDLE is entered.
- div_done is ignored in every state except WAIT. A late done after a timeout therefore never corrupts a later transaction.
- div_zero and timeout_err are cleared on the next ack, or when the block returns to IDLE after the flagged ack.
- req bits that are not granted are ignored. A requester must deassert req in the cycle after its ack. A req still high in IDLE is treated as a new request.
- Reset mid-operation: return to IDLE immediately with ptr = 0. No further div_start is issued. Any in-flight divider result is ignored.
- Reset values: all outputs 0 (gnt, ack, quotient, remainder, div_zero, timeout_err, busy, div_start, div_num, div_den). Internal state: ptr = 0, counter = 0.

## Timing
- Cycle 0: IDLE samples req.
- Cycle 1: ISSUE, with gnt and div_start high.
- Cycle 2: WAIT.
- With div_done high at cycle 1+L (divider latency L ≥ 1), ack is high at cycle 2+L and IDLE is re-entered at cycle 3+L.
- Zero denominator: ack at cycle 2.
- Timeout: ack at cycle 2+TIMEOUT.
- Back-to-back: a pending req is sampled in the cycle IDLE is re-entered. The next ISSUE therefore follows one idle cycle after ack.
- Throughput: one division per L+3 cycles.
- All outputs are registered. There is no combinational path from req or div_done to any output.

## Test plan
- Single request, no contention: req[2] with num = 1000, den = 7, mock divider L = 5, request seen in cycle 0.
  - Required: div_start pulse at cycle 1; ack[2] at cycle 7; quotient = 142, remainder = 6; flags low.
- Round-robin fairness: req = 4'b1111 held, each requester dropping req after its ack.
  - Required: grant order 0, 1, 2, 3.
  - Then re-raise req[0] and req[3] together after ptr = 0: 0 is granted before 3.
- Zero denominator: req[1] with num = 55, den = 0.
  - Required: no div_start; ack[1] at cycle 2; quotient = 0xFFFFFFFF, remainder = 55, div_zero = 1.
- Timeout: TIMEOUT = 8, mock divider never asserts done.
  - Required: ack at cycle 10 with timeout_err = 1 and quotient = 0.
  - Then inject a stray div_done in IDLE: no ack and no state change.
- Done/timeout coincidence: div_done arrives on the final WAIT cycle.
  - Required: div_done wins; the divider result is delivered with timeout_err = 0.
- Reset mid-WAIT: assert rst_n low during WAIT.
  - Required: all outputs 0 and busy = 0 at once.
  - After release, the divider completing produces no ack. A new req[3] is served normally with ptr starting at 0.

Source files
------------

// File: rtl/div_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one sequential divider among N_REQ
// requesters. Latches the winner's operands, starts the divider, waits for
// done (or times out), and returns the result with a one-cycle ack.
// Zero denominators bypass the divider entirely.
module div_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*W-1:0]   num_flat,
    input  logic [N_REQ*W-1:0]   den_flat,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     ack,
    output logic [W-1:0]         quotient,
    output logic [W-1:0]         remainder,
    output logic                 div_zero,
    output logic                 timeout_err,
    output logic                 busy,
    output logic                 div_start,
    output logic [W-1:0]         div_num,
    output logic [W-1:0]         div_den,
    input  logic                 div_done,
    input  logic [W-1:0]         div_quot,
    input  logic [W-1:0]         div_rem
);

    localparam int          IW = $clog2(N_REQ);
    localparam int          CW = $clog2(TIMEOUT);
    localparam int unsigned NR = N_REQ;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DELIVER
    } state_t;

    state_t              r_state;
    logic [IW-1:0]       r_ptr;
    logic [IW-1:0]       r_win;
    logic [CW-1:0]       r_cnt;
    logic [N_REQ-1:0]    r_gnt;
    logic [N_REQ-1:0]    r_ack;
    logic [W-1:0]        r_quot;
    logic [W-1:0]        r_rem;
    logic                r_div_zero;
    logic                r_timeout_err;
    logic                r_busy;
    logic                r_div_start;
    logic [W-1:0]        r_div_num;
    logic [W-1:0]        r_div_den;

    logic                w_any;
    logic                w_found;
    logic [IW-1:0]       w_win;
    int unsigned         w_idx;
    logic [W-1:0]        w_num_sel;
    logic [W-1:0]        w_den_sel;
    logic [N_REQ-1:0]    w_win_oh;

    // Round-robin pick: first requester at or after r_ptr, wrapping modulo N_REQ
    always_comb begin
        w_any   = |req;
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int unsigned k = 0; k < NR; k++) begin
            w_idx = (32'(r_ptr) + k) % NR;
            if (!w_found && req[IW'(w_idx)]) begin
                w_found = 1'b1;
                w_win   = IW'(w_idx);
            end
        end
        w_num_sel = num_flat[32'(w_win)*W +: W];
        w_den_sel = den_flat[32'(w_win)*W +: W];
        w_win_oh  = N_REQ'(1) << w_win;
    end

    // Sequencer FSM; every output is a register updated on state transitions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_win         <= '0;
            r_cnt         <= '0;
            r_gnt         <= '0;
            r_ack         <= '0;
            r_quot        <= '0;
            r_rem         <= '0;
            r_div_zero    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b0;
            r_div_start   <= 1'b0;
            r_div_num     <= '0;
            r_div_den     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_win       <= w_win;
                        r_div_num   <= w_num_sel;
                        r_div_den   <= w_den_sel;
                        r_gnt       <= w_win_oh;
                        r_busy      <= 1'b1;
                        // start is decided here so it is visible in the ISSUE cycle
                        r_div_start <= (w_den_sel != '0);
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_div_start <= 1'b0;
                    if (r_div_den == '0) begin
                        r_quot     <= '1;
                        r_rem      <= r_div_num;
                        r_div_zero <= 1'b1;
                        r_ack      <= r_gnt;
                        r_state    <= S_DELIVER;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (div_done) begin
                        r_quot  <= div_quot;
                        r_rem   <= div_rem;
                        r_ack   <= r_gnt;
                        r_state <= S_DELIVER;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_quot        <= '0;
                        r_rem         <= '0;
                        r_timeout_err <= 1'b1;
                        r_ack         <= r_gnt;
                        r_state       <= S_DELIVER;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DELIVER: begin
                    r_ack         <= '0;
                    r_gnt         <= '0;
                    r_div_zero    <= 1'b0;
                    r_timeout_err <= 1'b0;
                    r_busy        <= 1'b0;
                    r_ptr         <= (r_win == IW'(NR - 1)) ? '0 : r_win + 1'b1;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign ack         = r_ack;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_zero    = r_div_zero;
    assign timeout_err = r_timeout_err;
    assign busy        = r_busy;
    assign div_start   = r_div_start;
    assign div_num     = r_div_num;
    assign div_den     = r_div_den;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Scoreboard bench for div_share_arbiter: stimulus pushes expected acks and
// start pulses into queues, a monitor pops and compares them as they appear.
module tb_div_share_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N*W-1:0]   num_flat;
    logic [N*W-1:0]   den_flat;
    logic [N-1:0]     gnt;
    logic [N-1:0]     ack;
    logic [W-1:0]     quotient;
    logic [W-1:0]     remainder;
    logic             div_zero;
    logic             timeout_err;
    logic             busy;
    logic             div_start;
    logic [W-1:0]     div_num;
    logic [W-1:0]     div_den;
    logic             div_done;
    logic [W-1:0]     div_quot;
    logic [W-1:0]     div_rem;

    logic             mock_done;
    logic             stray_done;
    bit               mock_en;
    int unsigned      mock_lat;
    int unsigned      cyc = 0;
    int unsigned      total = 0;
    int unsigned      bad = 0;

    typedef struct {
        int unsigned idx;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        te;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned start_q[$];

    assign div_done = mock_done | stray_done;

    div_share_arbiter #(
        .N_REQ   (N),
        .W       (W),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .num_flat    (num_flat),
        .den_flat    (den_flat),
        .gnt         (gnt),
        .ack         (ack),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_zero    (div_zero),
        .timeout_err (timeout_err),
        .busy        (busy),
        .div_start   (div_start),
        .div_num     (div_num),
        .div_den     (div_den),
        .div_done    (div_done),
        .div_quot    (div_quot),
        .div_rem     (div_rem)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic set_op(input int unsigned i, input logic [31:0] n, input logic [31:0] d);
        num_flat[i*W +: W] = n;
        den_flat[i*W +: W] = d;
    endtask

    task automatic push_ack(input int unsigned idx, input logic [31:0] q, input logic [31:0] r,
                            input logic dz, input logic te, input int unsigned c);
        exp_t e;
        e.idx = idx;
        e.q   = q;
        e.r   = r;
        e.dz  = dz;
        e.te  = te;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_gnt"}, gnt, 0);
        check({tag, "_ack"}, ack, 0);
        check({tag, "_quotient"}, quotient, 0);
        check({tag, "_remainder"}, remainder, 0);
        check({tag, "_div_zero"}, div_zero, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_div_start"}, div_start, 0);
        check({tag, "_div_num"}, div_num, 0);
        check({tag, "_div_den"}, div_den, 0);
    endtask

    // Requesters drop req after their ack; returns once all expected acks are seen and idle
    task automatic drain(input string name);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            req = req & ~ack;
            if (exp_q.size() == 0 && !busy && req == '0) return;
        end
        check({name, "_budget"}, 0, 1);
    endtask

    // Mock divider: responds L cycles after a start pulse, then drives junk results
    initial begin
        logic [31:0] n, d;
        int unsigned lat;
        mock_done = 1'b0;
        div_quot  = '0;
        div_rem   = '0;
        forever begin
            @(negedge clk);
            if (div_start && mock_en) begin
                n   = div_num;
                d   = div_den;
                lat = mock_lat;
                repeat (lat) @(negedge clk);
                mock_done = 1'b1;
                div_quot  = (d == 0) ? '1 : n / d;
                div_rem   = (d == 0) ? n : n % d;
                @(negedge clk);
                mock_done = 1'b0;
                div_quot  = 32'hDEAD_BEEF;
                div_rem   = 32'hDEAD_BEEF;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT acks or starts the divider
    initial begin
        exp_t        e;
        int unsigned s;
        bit          prev_ack;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_ack) check("post_ack_clear", {gnt, div_zero, timeout_err}, 0);
                if (ack != '0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_ack", ack, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("ack_onehot", ack, 64'd1 << e.idx);
                        check("ack_cycle", cyc, e.cyc);
                        check("quotient", quotient, e.q);
                        check("remainder", remainder, e.r);
                        check("div_zero", div_zero, e.dz);
                        check("timeout_err", timeout_err, e.te);
                    end
                end
                if (div_start) begin
                    if (start_q.size() == 0) begin
                        check("unexpected_start", div_start, 0);
                    end else begin
                        s = start_q.pop_front();
                        check("start_cycle", cyc, s);
                    end
                end
                prev_ack = (ack != '0);
            end else begin
                prev_ack = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c;
        rst_n      = 1'b0;
        req        = '0;
        num_flat   = '0;
        den_flat   = '0;
        stray_done = 1'b0;
        mock_en    = 1'b1;
        mock_lat   = 2;

        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Round-robin with all four requesting, ptr starting at 0
        set_op(0, 100, 9);
        set_op(1, 77, 7);
        set_op(2, 1000, 7);
        set_op(3, 32'hFFFF_FFFF, 16);
        @(negedge clk);
        c   = cyc;
        req = 4'b1111;
        push_ack(0, 11, 1, 0, 0, c + 4);
        push_ack(1, 11, 0, 0, 0, c + 9);
        push_ack(2, 142, 6, 0, 0, c + 14);
        push_ack(3, 32'h0FFF_FFFF, 15, 0, 0, c + 19);
        start_q.push_back(c + 1);
        start_q.push_back(c + 6);
        start_q.push_back(c + 11);
        start_q.push_back(c + 16);
        drain("rr_all");

        // ptr wrapped to 0: requester 0 beats requester 3
        @(negedge clk);
        c   = cyc;
        req = 4'b1001;
        push_ack(0, 11, 1, 0, 0, c + 4);
        push_ack(3, 32'h0FFF_FFFF, 15, 0, 0, c + 9);
        start_q.push_back(c + 1);
        start_q.push_back(c + 6);
        drain("rr_0_3");

        // Single request, divider latency 5
        mock_lat = 5;
        @(negedge clk);
        c   = cyc;
        req = 4'b0100;
        push_ack(2, 142, 6, 0, 0, c + 7);
        start_q.push_back(c + 1);
        drain("single");

        // Zero denominator bypass
        set_op(1, 55, 0);
        @(negedge clk);
        c   = cyc;
        req = 4'b0010;
        push_ack(1, 32'hFFFF_FFFF, 55, 1, 0, c + 2);
        drain("zero_den");

        // Divider never answers
        mock_en = 1'b0;
        set_op(0, 5, 3);
        @(negedge clk);
        c   = cyc;
        req = 4'b0001;
        push_ack(0, 0, 0, 0, 1, c + 10);
        start_q.push_back(c + 1);
        drain("timeout");
        mock_en = 1'b1;

        // Stray done while idle must change nothing
        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stray_busy", busy, 0);
            check("stray_ack", ack, 0);
        end
        check("stray_quot_held", quotient, 0);
        check("stray_rem_held", remainder, 0);

        // Done on the last WAIT cycle wins over timeout
        mock_lat = 8;
        set_op(1, 200, 3);
        @(negedge clk);
        c   = cyc;
        req = 4'b0010;
        push_ack(1, 66, 2, 0, 0, c + 10);
        start_q.push_back(c + 1);
        drain("coincide");

        // Reset in the middle of WAIT
        mock_lat = 5;
        set_op(2, 50, 5);
        @(negedge clk);
        c   = cyc;
        req = 4'b0100;
        start_q.push_back(c + 1);
        repeat (3) @(negedge clk);
        check("wait_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("late_done_busy", busy, 0);
            check("late_done_ack", ack, 0);
        end

        // ptr restarted at 0: requester 1 precedes requester 3
        mock_lat = 2;
        set_op(1, 12, 5);
        set_op(3, 90, 4);
        @(negedge clk);
        c   = cyc;
        req = 4'b1010;
        push_ack(1, 2, 2, 0, 0, c + 4);
        push_ack(3, 22, 2, 0, 0, c + 9);
        start_q.push_back(c + 1);
        start_q.push_back(c + 6);
        drain("post_reset");

        check("leftover_starts", start_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
